// File: rtl/instr_fetch_if.sv
// Bus bundle between the instruction fetch unit, its IRAM and the instruction consumer.
// master = fetch unit side, slave = IRAM/consumer side.
interface instr_fetch_if;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          instr_ready;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] iram_address;
    logic          iram_rden;
    logic          iram_wren;
    logic [DW-1:0] iram_data;
    logic [DW-1:0] iram_q;

    modport master (
        input  instr_ready,
        input  iram_q,
        output instr_valid,
        output instr,
        output iram_address,
        output iram_rden,
        output iram_wren,
        output iram_data
    );

    modport slave (
        output instr_ready,
        output iram_q,
        input  instr_valid,
        input  instr,
        input  iram_address,
        input  iram_rden,
        input  iram_wren,
        input  iram_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch from a 1-cycle-latency IRAM with redirect support.
// Optional halt-on-8'hFF detection is enabled by defining IFETCH_HALT_DETECT_EN.
module instr_fetch (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 jump,
    input  logic [7:0]           jump_addr,
    output logic [7:0]           pc,
    output logic                 halted,
    instr_fetch_if.master        bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam logic [DW-1:0] HALT_OPCODE = DW'(8'hFF);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
`ifdef IFETCH_HALT_DETECT_EN
        PRESENT = 3'd3,
        HALT    = 3'd4
`else
        PRESENT = 3'd3
`endif
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] pc_next;
    logic [DW-1:0] instr_q;
    logic [DW-1:0] instr_next;
    logic          valid_q;
    logic          rden_q;
`ifdef IFETCH_HALT_DETECT_EN
    logic          halted_q;
`endif

    // Next-state and datapath update; a jump always wins and never advances pc
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr_q;
        case (state)
            IDLE: begin
                if (jump) begin
                    pc_next = jump_addr;
                end else if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (jump) begin
                    pc_next    = jump_addr;
                    state_next = REQ;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (jump) begin
                    pc_next    = jump_addr;
                    state_next = REQ;
`ifdef IFETCH_HALT_DETECT_EN
                end else if (bus.iram_q == HALT_OPCODE) begin
                    instr_next = HALT_OPCODE;
                    state_next = HALT;
`endif
                end else begin
                    instr_next = bus.iram_q;
                    pc_next    = AW'(pc + AW'(1));
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (jump) begin
                    pc_next    = jump_addr;
                    state_next = REQ;
                end else if (bus.instr_ready) begin
                    state_next = REQ;
                end
            end
`ifdef IFETCH_HALT_DETECT_EN
            HALT: begin
                if (jump) begin
                    pc_next    = jump_addr;
                    state_next = REQ;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; status outputs are registered decodes of the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            rden_q   <= 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            instr_q  <= instr_next;
            valid_q  <= (state_next == PRESENT);
            rden_q   <= (state_next == REQ);
`ifdef IFETCH_HALT_DETECT_EN
            halted_q <= (state_next == HALT);
`endif
        end
    end

`ifdef IFETCH_HALT_DETECT_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign bus.instr_valid  = valid_q;
    assign bus.instr        = instr_q;
    assign bus.iram_rden    = rden_q;
    assign bus.iram_address = pc;
    assign bus.iram_wren    = 1'b0;
    assign bus.iram_data    = '0;
endmodule
